// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// CPU-side UART transmitter. Bytes written by the CPU are queued in a small
// circular FIFO and serialised 8N1, LSB first, onto the PC-bound UART line.
// Consecutive queued bytes are sent as contiguous frames: the next start bit
// directly follows the previous stop bit.
//
// Ports:
//   iCpuClock         in   clock, rising edge
//   iCpuReset         in   asynchronous active-low reset
//   iDoUartWrite      in   push request, one byte per cycle while high
//   iUartDataToWrite  in   byte to push
//   iClearOverflow    in   clears oOverflow (a same-edge drop wins)
//   oUartToPc         out  registered serial line, idle high
//   oTxFull           out  FIFO count == depth
//   oTxEmpty          out  FIFO count == 0
//   oTxBusy           out  frame in progress or FIFO non-empty
//   oOverflow         out  sticky: a write was dropped while full
//   oFifoCount        out  FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 180,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     iCpuClock,
  input  logic                     iCpuReset,
  input  logic                     iDoUartWrite,
  input  logic [7:0]               iUartDataToWrite,
  input  logic                     iClearOverflow,
  output logic                     oUartToPc,
  output logic                     oTxFull,
  output logic                     oTxEmpty,
  output logic                     oTxBusy,
  output logic                     oOverflow,
  output logic [FIFO_DEPTH_LOG2:0] oFifoCount
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int PTR_W  = FIFO_DEPTH_LOG2;
  localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full_q, empty_q;

  // Serialiser
  state_e           state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             line_q;
  logic             busy_q;

  logic full_s, nonempty_s, baud_end_s, push_s, pop_s, drop_s;
  logic [7:0] rd_data_s;

  // Full is judged on the pre-edge count, so a same-edge pop never rescues a write.
  assign full_s     = (count_q == CNT_FULL);
  assign nonempty_s = (count_q != CNT_ZERO);
  assign baud_end_s = (baud_q == BAUD_LAST);
  assign push_s     = iDoUartWrite & ~full_s;
  assign drop_s     = iDoUartWrite & full_s;
  // The FSM loads a byte from IDLE, or at the last cycle of STOP to keep frames contiguous.
  assign pop_s      = nonempty_s & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_end_s));
  assign rd_data_s  = mem_q[rd_ptr_q];

  // Next-state for FIFO pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop on the same edge as a clear keeps the flag set.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (iClearOverflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO data array; contents need no reset because the count guards every read.
  always_ff @(posedge iCpuClock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= iUartDataToWrite;
    end
  end

  // FIFO pointer, occupancy and status-flag registers.
  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= CNT_ZERO;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      full_q   <= (count_d == CNT_FULL);
      empty_q  <= (count_d == CNT_ZERO);
    end
  end

  // Transmit FSM: the line level is registered alongside the state it belongs to.
  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      state_q <= ST_IDLE;
      baud_q  <= BAUD_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baud_q <= BAUD_ZERO;
          bit_q  <= 3'd0;
          if (pop_s) begin
            shift_q <= rd_data_s;
            state_q <= ST_START;
            line_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            line_q  <= 1'b1;
            busy_q  <= (count_d != CNT_ZERO);
          end
        end

        ST_START: begin
          busy_q <= 1'b1;
          if (baud_end_s) begin
            baud_q  <= BAUD_ZERO;
            bit_q   <= 3'd0;
            state_q <= ST_DATA;
            line_q  <= shift_q[0];
          end else begin
            baud_q  <= baud_q + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          busy_q <= 1'b1;
          if (baud_end_s) begin
            baud_q <= BAUD_ZERO;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
              line_q  <= 1'b1;
            end else begin
              // Next bit is shift_q[1], i.e. bit 0 after the shift lands.
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              line_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (baud_end_s) begin
            baud_q <= BAUD_ZERO;
            bit_q  <= 3'd0;
            if (pop_s) begin
              shift_q <= rd_data_s;
              state_q <= ST_START;
              line_q  <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              line_q  <= 1'b1;
              busy_q  <= (count_d != CNT_ZERO);
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
            busy_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          baud_q  <= BAUD_ZERO;
          bit_q   <= 3'd0;
          line_q  <= 1'b1;
          busy_q  <= (count_d != CNT_ZERO);
        end
      endcase
    end
  end

  assign oUartToPc  = line_q;
  assign oTxFull    = full_q;
  assign oTxEmpty   = empty_q;
  assign oTxBusy    = busy_q;
  assign oOverflow  = ovf_q;
  assign oFifoCount = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DLOG2 = 2;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic [7:0] wdata;
  logic       clr;
  logic       line;
  logic       full;
  logic       empty;
  logic       busy;
  logic       ovf;
  logic [DLOG2:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic log_en = 1'b0;
  logic line_log[$];
  logic [7:0] exp_bytes[$];

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       line;
    logic       busy;
  } vec_t;

  vec_t tbl[9];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DLOG2)) dut (
    .iCpuClock        (clk),
    .iCpuReset        (rst_n),
    .iDoUartWrite     (wr),
    .iUartDataToWrite (wdata),
    .iClearOverflow   (clr),
    .oUartToPc        (line),
    .oTxFull          (full),
    .oTxEmpty         (empty),
    .oTxBusy          (busy),
    .oOverflow        (ovf),
    .oFifoCount       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (log_en) line_log.push_back(line);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    chk({name, " idle-timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // Decode recorded samples against exp_bytes: each frame must be an exact
  // 40-sample waveform, frames back to back, line high everywhere else.
  task automatic check_log(input string name);
    int s;
    int nz;
    int bad;
    int base;
    int slot;
    logic lvl;
    logic [7:0] got;
    s = -1;
    for (int i = 0; i < line_log.size(); i++) begin
      if (line_log[i] == 1'b0) begin
        s = i;
        break;
      end
    end
    if (exp_bytes.size() == 0) begin
      nz = 0;
      foreach (line_log[i]) if (line_log[i] !== 1'b1) nz++;
      chk({name, " quiet-line"}, nz, 0);
      return;
    end
    chk({name, " start-found"}, {31'd0, (s >= 0)}, 32'd1);
    if (s < 0) return;
    for (int f = 0; f < exp_bytes.size(); f++) begin
      base = s + f * FRAME;
      if (base + FRAME > line_log.size()) begin
        chk({name, " frame-truncated"}, base + FRAME, line_log.size());
        return;
      end
      bad = 0;
      got = 8'h00;
      for (int k = 0; k < FRAME; k++) begin
        slot = k / CPB;
        if (slot == 0) lvl = 1'b0;
        else if (slot == 9) lvl = 1'b1;
        else lvl = exp_bytes[f][slot-1];
        if (line_log[base+k] !== lvl) bad++;
        if (slot >= 1 && slot <= 8 && (k % CPB) == 2) got[slot-1] = line_log[base+k];
      end
      chk($sformatf("%s frame%0d-data", name, f), got, exp_bytes[f]);
      chk($sformatf("%s frame%0d-shape", name, f), bad, 0);
    end
    nz = 0;
    for (int i = s + exp_bytes.size() * FRAME; i < line_log.size(); i++) begin
      if (line_log[i] !== 1'b1) nz++;
    end
    chk({name, " trailing-idle"}, nz, 0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, " line"},  {31'd0, line},  32'd1);
    chk({name, " empty"}, {31'd0, empty}, 32'd1);
    chk({name, " full"},  {31'd0, full},  32'd0);
    chk({name, " busy"},  {31'd0, busy},  32'd0);
    chk({name, " ovf"},   {31'd0, ovf},   32'd0);
    chk({name, " count"}, {29'd0, count}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    wdata = 8'h00;
    clr   = 1'b0;

    // Overflow / clear-vs-set table: {wr, data, clr, cnt, full, empty, ovf, line, busy}
    tbl[0] = '{1'b1, 8'h10, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h12, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h13, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h14, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h15, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h16, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // 1. Reset and quiet period
    repeat (5) tick();
    check_idle_outputs("rst-held");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("rst-released");
    line_log.delete();
    exp_bytes.delete();
    log_en = 1'b1;
    repeat (100) tick();
    log_en = 1'b0;
    check_log("quiet");
    chk("quiet busy", {31'd0, busy}, 32'd0);

    // 2. Single byte 0x55 with exact latency and busy-drop edge
    line_log.delete();
    exp_bytes.delete();
    exp_bytes.push_back(8'h55);
    log_en = 1'b1;
    wr = 1'b1; wdata = 8'h55;
    tick();                                   // E0
    wr = 1'b0;
    chk("single E0 line",  {31'd0, line}, 32'd1);
    chk("single E0 count", {29'd0, count}, 32'd1);
    chk("single E0 busy",  {31'd0, busy}, 32'd1);
    tick();                                   // E1
    chk("single E1 line",  {31'd0, line}, 32'd0);
    chk("single E1 count", {29'd0, count}, 32'd0);
    chk("single E1 empty", {31'd0, empty}, 32'd1);
    repeat (FRAME - 1) tick();                // E40: last stop cycle
    chk("single E40 line", {31'd0, line}, 32'd1);
    chk("single E40 busy", {31'd0, busy}, 32'd1);
    tick();                                   // E41: frame over
    chk("single E41 busy", {31'd0, busy}, 32'd0);
    repeat (10) tick();
    log_en = 1'b0;
    check_log("single");

    // 3. Back-to-back 00, FF, A5
    line_log.delete();
    exp_bytes.delete();
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(8'hA5);
    log_en = 1'b1;
    wr = 1'b1;
    wdata = 8'h00; tick();
    wdata = 8'hFF; tick();
    wdata = 8'hA5; tick();
    wr = 1'b0;
    wait_idle("b2b", 300);
    repeat (10) tick();
    log_en = 1'b0;
    check_log("b2b");

    // 4/5. Overflow and clear-vs-set, table driven
    line_log.delete();
    exp_bytes.delete();
    for (int b = 0; b < 5; b++) exp_bytes.push_back(8'h10 + 8'(b));
    log_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr = tbl[i].wr; wdata = tbl[i].data; clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d count", i), {29'd0, count}, {29'd0, tbl[i].cnt});
      chk($sformatf("tbl%0d full", i),  {31'd0, full},  {31'd0, tbl[i].full});
      chk($sformatf("tbl%0d empty", i), {31'd0, empty}, {31'd0, tbl[i].empty});
      chk($sformatf("tbl%0d ovf", i),   {31'd0, ovf},   {31'd0, tbl[i].ovf});
      chk($sformatf("tbl%0d line", i),  {31'd0, line},  {31'd0, tbl[i].line});
      chk($sformatf("tbl%0d busy", i),  {31'd0, busy},  {31'd0, tbl[i].busy});
    end
    wr = 1'b0; clr = 1'b0;
    wait_idle("ovf", 400);
    repeat (10) tick();
    log_en = 1'b0;
    check_log("ovf");
    check_idle_outputs("ovf-done");

    // 6. Reset during data bit 3 of 0xC3 with two bytes queued
    line_log.delete();
    exp_bytes.delete();
    wr = 1'b1;
    wdata = 8'hC3; tick();                    // E0
    wdata = 8'h11; tick();                    // E1: pop C3, start
    wdata = 8'h22; tick();                    // E2
    wr = 1'b0;
    repeat (15) tick();                       // E17: bit 3 begins
    tick();                                   // E18: inside bit 3
    chk("midrst bit3 line", {31'd0, line}, 32'd0);
    chk("midrst pre count", {29'd0, count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst async line",  {31'd0, line},  32'd1);
    chk("midrst async count", {29'd0, count}, 32'd0);
    chk("midrst async empty", {31'd0, empty}, 32'd1);
    chk("midrst async busy",  {31'd0, busy},  32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    log_en = 1'b1;
    repeat (100) tick();
    log_en = 1'b0;
    check_log("midrst");
    check_idle_outputs("midrst-after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
